// File: rtl/i2c_sync_fifo.sv
// ---------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock FIFO between the APB slave front end and the I2C core. The same
// module serves as the TX FIFO (APB writes, I2C core drains) and the RX FIFO
// (I2C core writes, APB reads). Reads are show-ahead: RD_DATA always presents
// the head entry, so a zero-wait APB read sees data in the same cycle it pops.
//
// Ports
//   PCLK         clock, all state changes on the rising edge
//   PRESETn      synchronous active-low reset
//   WR_EN        push request, WR_DATA is the word to push
//   RD_EN        pop request, RD_DATA is the current head (0 when EMPTY)
//   CLR_ERR      clears the sticky OVERFLOW / UNDERFLOW flags
//   EMPTY        LEVEL == 0
//   FULL         LEVEL == DEPTH
//   ALMOST_FULL  LEVEL >= AF_LEVEL
//   LEVEL        number of stored entries, 0..DEPTH
//   OVERFLOW     sticky, push attempted while full and not popping
//   UNDERFLOW    sticky, pop attempted while empty
//
// Request semantics: WR_EN and RD_EN are sampled at the rising edge and there
// is no back-pressure handshake. A push is taken when WR_EN is high and the
// FIFO is not full, or when it is full but a pop is taken in the same cycle.
// A pop is taken when RD_EN is high and the FIFO is not empty. Rejected
// requests leave contents untouched and set the matching sticky flag.
// ---------------------------------------------------------------------------
module i2c_sync_fifo #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] RD_DATA,
  input  logic              CLR_ERR,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic [AWIDTH:0]   LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);
  localparam logic [AWIDTH:0]   LVL_ONE   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0]   LVL_DEPTH = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   LVL_AF    = (AWIDTH+1)'(AF_LEVEL);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic empty, full;
  logic push, pop;
  logic ovf_evt, unf_evt;

  // Status comes only from the registered level, never from pointer equality,
  // so no combinational path exists from the requests to the flags.
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_DEPTH);

  assign push = WR_EN & (~full | RD_EN);
  assign pop  = RD_EN & ~empty;

  assign ovf_evt = WR_EN & full & ~RD_EN;
  assign unf_evt = RD_EN & empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
    // An error event in the same cycle as CLR_ERR keeps the flag set.
    ovf_d = ovf_evt | (ovf_q & ~CLR_ERR);
    unf_d = unf_evt | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; a write during reset is discarded. When full with a
  // simultaneous push and pop, wr_ptr equals rd_ptr, so the new word lands in
  // the slot being popped and becomes the youngest entry.
  always_ff @(posedge PCLK) begin
    if (PRESETn && push) mem[wr_ptr_q] <= WR_DATA;
  end

  assign RD_DATA     = empty ? '0 : mem[rd_ptr_q];
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOST_FULL = (level_q >= LVL_AF);
  assign LEVEL       = level_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule
